// File: rtl/drv_switch_pkg.sv
// Shared types and helpers for the switch-row driver family.
package drv_switch_pkg;

  typedef enum logic {
    EVT_CLICK   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_t;

  // Width of a switch index for a row of n switches; never narrower than one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drv_fifo_sync.sv
// Single-clock show-ahead FIFO with occupancy count.
// Head data is read straight from storage, so it is valid whenever o_empty is low.
// A push while full is accepted only when a pop happens in the same cycle.
module drv_fifo_sync #(
  parameter int unsigned p_data_w = 8,
  parameter int unsigned p_depth  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [p_data_w-1:0]       i_data,
  input  logic                      i_pop,
  output logic [p_data_w-1:0]       o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(p_depth):0]  o_count
);

  localparam int unsigned AW = $clog2(p_depth);

  logic [p_data_w-1:0] mem [p_depth];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                push_ok;
  logic                pop_ok;

  // Qualify requests against occupancy; a full FIFO takes a push only alongside a pop.
  always_comb begin
    pop_ok  = i_pop & ~o_empty;
    push_ok = i_push & (~o_full | pop_ok);
  end

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < p_depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_full  = (count == (AW + 1)'(p_depth));
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/drv_switch_event_queue.sv
// Serialises per-switch click/release pulses into an ordered {kind, index}
// event stream, buffered in a FIFO and presented on a valid/ready port.
// Each switch has one pending flag per event kind; a pulse landing on a flag
// that is still waiting is lost and recorded in the sticky overflow flag.
module drv_switch_event_queue
  import drv_switch_pkg::*;
#(
  parameter int unsigned p_width = 4,
  parameter int unsigned p_depth = 8,
  localparam int unsigned IW = idx_w(int'(p_width)),
  localparam int unsigned CW = $clog2(p_depth) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_click,
  input  logic [p_width-1:0] i_release,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_kind,
  output logic [IW-1:0]      o_index,
  output logic [CW-1:0]      o_count,
  output logic               o_overflow,
  input  logic               i_ovf_clr
);

  logic [p_width-1:0] r_pc;
  logic [p_width-1:0] r_pr;
  logic [p_width-1:0] grant_pc;
  logic [p_width-1:0] grant_pr;
  logic               req_valid;
  evt_kind_t          req_kind;
  logic [IW-1:0]      req_idx;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               can_push;
  logic               push;
  logic [IW:0]        fifo_din;
  logic [IW:0]        fifo_dout;
  logic               ovf_hit;
  logic               r_ovf;

  // Room for one more event this cycle: not full, or a slot frees by a pop.
  always_comb begin
    pop      = ~fifo_empty & i_ready;
    can_push = ~fifo_full | pop;
  end

  // Fixed-priority arbiter: lowest pending index wins, click before release.
  always_comb begin
    req_valid = 1'b0;
    req_kind  = EVT_CLICK;
    req_idx   = '0;
    grant_pc  = '0;
    grant_pr  = '0;
    for (int unsigned i = 0; i < p_width; i++) begin
      if (!req_valid && (r_pc[i] || r_pr[i])) begin
        req_valid   = 1'b1;
        req_idx     = IW'(i);
        req_kind    = r_pc[i] ? EVT_CLICK : EVT_RELEASE;
        grant_pc[i] = can_push & r_pc[i];
        grant_pr[i] = can_push & ~r_pc[i];
      end
    end
    push     = req_valid & can_push;
    fifo_din = {req_kind, req_idx};
  end

  // A pulse is lost only if its flag is still pending and not being granted now.
  always_comb begin
    ovf_hit = (|(i_click & r_pc & ~grant_pc)) | (|(i_release & r_pr & ~grant_pr));
  end

  // Pending flags: granted flags clear, new pulses set (set wins over clear).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc <= '0;
      r_pr <= '0;
    end else begin
      r_pc <= (r_pc & ~grant_pc) | i_click;
      r_pr <= (r_pr & ~grant_pr) | i_release;
    end
  end

  // Sticky overflow flag; a fresh loss beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ovf <= 1'b0;
    end else if (ovf_hit) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  drv_fifo_sync #(
    .p_data_w (IW + 1),
    .p_depth  (p_depth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (fifo_din),
    .i_pop   (pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

  assign o_valid    = ~fifo_empty;
  assign o_kind     = fifo_dout[IW];
  assign o_index    = fifo_dout[IW-1:0];
  assign o_overflow = r_ovf;

endmodule
